// File: rtl/blade_pkg.sv
// Shared encodings for the blade length controller: FSM states, clamp result codes
// and unit constants.
package blade_pkg;

    typedef enum logic [1:0] {
        StOff     = 2'd0,
        StSlew    = 2'd1,
        StOn      = 2'd2,
        StRetract = 2'd3
    } blade_state_e;

    typedef enum logic [2:0] {
        ClampOk      = 3'd0,
        ClampNeg     = 3'd1,
        ClampZero    = 3'd2,
        ClampOver    = 3'd3,
        ClampNorm    = 3'd4,
        ClampNoBlade = 3'd5
    } clamp_code_e;

    localparam int unsigned CmPerM = 100;

    function automatic int unsigned popcount8(logic [7:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/blade_len_validate.sv
// Combinational validator: folds a signed meters/centimeters request into one
// clamped centimeter target and reports which rule fired.
module blade_len_validate
    import blade_pkg::*;
#(
    parameter int unsigned W          = 16,
    parameter int unsigned NUM_BLADES = 2,
    parameter int unsigned MAX_CM     = 100,
    parameter int unsigned MIN_CM     = 50
) (
    input  logic [W-1:0]          cfg_m_i,
    input  logic [W-1:0]          cfg_cm_i,
    input  logic [NUM_BLADES-1:0] cfg_mask_i,
    output logic [W-1:0]          target_o,
    output logic [2:0]            code_o
);

    localparam int unsigned TW = W + 8;
    localparam logic signed [TW-1:0] CmPerMS = TW'(CmPerM);
    localparam logic signed [TW-1:0] MaxS    = TW'(MAX_CM);
    localparam logic signed [TW-1:0] NormS   = TW'(CmPerM - 1);

    logic signed [TW-1:0] m_ext;
    logic signed [TW-1:0] cm_ext;
    logic signed [TW-1:0] total;

    assign m_ext  = {{8{cfg_m_i[W-1]}}, cfg_m_i};
    assign cm_ext = {{8{cfg_cm_i[W-1]}}, cfg_cm_i};
    assign total  = m_ext * CmPerMS + cm_ext;

    // First matching rule wins; a NO_BLADE target is ignored by the caller.
    always_comb begin
        target_o = total[W-1:0];
        code_o   = ClampOk;
        if (cfg_mask_i == '0) begin
            code_o = ClampNoBlade;
        end else if (m_ext[TW-1] || cm_ext[TW-1]) begin
            code_o   = ClampNeg;
            target_o = W'(MIN_CM);
        end else if (total == '0) begin
            code_o   = ClampZero;
            target_o = W'(MIN_CM);
        end else if (total > MaxS) begin
            code_o   = ClampOver;
            target_o = W'(MAX_CM);
        end else if (cm_ext > NormS) begin
            code_o = ClampNorm;
        end
    end

endmodule

// File: rtl/blade_length_ctrl.sv
// Multi-blade length controller: accepts validated length requests and ramps each
// enabled blade toward the common target through an ignite/slew/on/retract FSM.
module blade_length_ctrl
    import blade_pkg::*;
#(
    parameter int unsigned NUM_BLADES = 2,
    parameter int unsigned W          = 16,
    parameter int unsigned MAX_CM     = 100,
    parameter int unsigned MIN_CM     = 50,
    parameter int unsigned STEP_CM    = 5,
    parameter int unsigned HILT_CM    = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [W-1:0]            cfg_m,
    input  logic [W-1:0]            cfg_cm,
    input  logic [NUM_BLADES-1:0]   cfg_mask,
    input  logic                    ignite,
    input  logic                    retract,
    output logic [NUM_BLADES*W-1:0] len_cm,
    output logic [W-1:0]            target_cm,
    output logic [W-1:0]            hilt_cm,
    output logic [1:0]              state,
    output logic [2:0]              clamp_code
);

    blade_state_e            state_q;
    logic [NUM_BLADES*W-1:0] len_q;
    logic [W-1:0]            target_q;
    logic [NUM_BLADES-1:0]   mask_q;
    logic [W-1:0]            hilt_q;
    logic [2:0]              clamp_q;

    logic [W-1:0]            v_target;
    logic [2:0]              v_code;
    logic                    accept;
    logic                    load;
    logic [NUM_BLADES-1:0]   mask_next;
    logic [NUM_BLADES*W-1:0] slew_len;
    logic [NUM_BLADES*W-1:0] dec_len;
    logic [NUM_BLADES-1:0]   at_goal;
    logic [NUM_BLADES-1:0]   at_zero;

    blade_len_validate #(
        .W          (W),
        .NUM_BLADES (NUM_BLADES),
        .MAX_CM     (MAX_CM),
        .MIN_CM     (MIN_CM)
    ) u_validate (
        .cfg_m_i    (cfg_m),
        .cfg_cm_i   (cfg_cm),
        .cfg_mask_i (cfg_mask),
        .target_o   (v_target),
        .code_o     (v_code)
    );

    // Retract in ON outranks a pending request, so the request is held off.
    assign cfg_ready = ((state_q == StOff) || (state_q == StOn)) && !rst &&
                       !(retract && (state_q == StOn));
    assign accept    = cfg_valid && cfg_ready;
    assign load      = accept && (v_code != ClampNoBlade);
    assign mask_next = load ? cfg_mask : mask_q;

    for (genvar i = 0; i < NUM_BLADES; i++) begin : g_blade
        logic [W-1:0] cur;
        logic [W-1:0] goal;
        logic [W:0]   up;
        logic [W-1:0] slew;
        logic [W-1:0] dec;

        assign cur  = len_q[i*W +: W];
        assign goal = mask_q[i] ? target_q : '0;
        assign up   = {1'b0, cur} + (W+1)'(STEP_CM);

        always_comb begin
            if (cur < goal) begin
                slew = (up > {1'b0, goal}) ? goal : up[W-1:0];
            end else if ((cur - goal) > W'(STEP_CM)) begin
                slew = cur - W'(STEP_CM);
            end else begin
                slew = goal;
            end
            dec = (cur > W'(STEP_CM)) ? cur - W'(STEP_CM) : '0;
        end

        assign slew_len[i*W +: W] = slew;
        assign dec_len[i*W +: W]  = dec;
        assign at_goal[i]         = (slew == goal);
        assign at_zero[i]         = (dec == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StOff;
            len_q    <= '0;
            target_q <= W'(MIN_CM);
            mask_q   <= '0;
            hilt_q   <= '0;
            clamp_q  <= ClampOk;
        end else begin
            if (accept) begin
                clamp_q <= v_code;
            end
            if (load) begin
                target_q <= v_target;
                mask_q   <= cfg_mask;
            end
            hilt_q <= (popcount8(8'(mask_q)) >= 2) ? W'(HILT_CM) : '0;

            unique case (state_q)
                StOff: begin
                    if (ignite && !retract && (mask_next != '0)) begin
                        state_q <= StSlew;
                    end
                end
                StSlew: begin
                    if (retract) begin
                        state_q <= StRetract;
                    end else begin
                        len_q <= slew_len;
                        if (&at_goal) begin
                            state_q <= StOn;
                        end
                    end
                end
                StOn: begin
                    if (retract) begin
                        state_q <= StRetract;
                    end else if (load && ((v_target != target_q) || (cfg_mask != mask_q))) begin
                        state_q <= StSlew;
                    end
                end
                StRetract: begin
                    len_q <= dec_len;
                    if (&at_zero) begin
                        state_q <= StOff;
                    end
                end
            endcase
        end
    end

    assign len_cm     = len_q;
    assign target_cm  = target_q;
    assign hilt_cm    = hilt_q;
    assign state      = state_q;
    assign clamp_code = clamp_q;

endmodule

// File: tb/tb_blade_length_ctrl.sv
// Directed, table-driven bench for blade_length_ctrl with hand-written ramp sequences.
module tb_blade_length_ctrl;

    localparam int NB = 2;
    localparam int W  = 16;

    logic          clk;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [W-1:0]  cfg_m;
    logic [W-1:0]  cfg_cm;
    logic [NB-1:0] cfg_mask;
    logic          ignite;
    logic          retract;
    logic [NB*W-1:0] len_cm;
    logic [W-1:0]  target_cm;
    logic [W-1:0]  hilt_cm;
    logic [1:0]    state;
    logic [2:0]    clamp_code;

    int checks;
    int failures;

    blade_length_ctrl #(
        .NUM_BLADES (NB),
        .W          (W),
        .MAX_CM     (100),
        .MIN_CM     (50),
        .STEP_CM    (5),
        .HILT_CM    (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_m      (cfg_m),
        .cfg_cm     (cfg_cm),
        .cfg_mask   (cfg_mask),
        .ignite     (ignite),
        .retract    (retract),
        .len_cm     (len_cm),
        .target_cm  (target_cm),
        .hilt_cm    (hilt_cm),
        .state      (state),
        .clamp_code (clamp_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v;
        int         m;
        int         cm;
        logic [1:0] mask;
        logic       ign;
        logic       ret;
        int         rdy;
        int         st;
        int         l0;
        int         l1;
        int         tgt;
        int         hilt;
        int         code;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, int m, int cm, logic [1:0] mask, logic ign,
                                logic ret, int rdy, int st, int l0, int l1, int tgt, int hilt,
                                int code);
        vec_t x;
        x.rst = r;   x.v = v;     x.m = m;     x.cm = cm;   x.mask = mask;
        x.ign = ign; x.ret = ret; x.rdy = rdy; x.st = st;   x.l0 = l0;
        x.l1 = l1;   x.tgt = tgt; x.hilt = hilt; x.code = code;
        return x;
    endfunction

    task automatic chk(string name, int row, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL row %0d %s: got %0d expected %0d", row, name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check ready before the edge and state after it.
    task automatic apply(vec_t x, int row);
        @(negedge clk);
        rst       = x.rst;
        cfg_valid = x.v;
        cfg_m     = W'(x.m);
        cfg_cm    = W'(x.cm);
        cfg_mask  = x.mask;
        ignite    = x.ign;
        retract   = x.ret;
        #1;
        chk("cfg_ready", row, int'(cfg_ready), x.rdy);
        @(posedge clk);
        #1;
        chk("state", row, int'(state), x.st);
        chk("len0", row, int'(len_cm[0 +: W]), x.l0);
        chk("len1", row, int'(len_cm[W +: W]), x.l1);
        chk("target_cm", row, int'(target_cm), x.tgt);
        chk("hilt_cm", row, int'(hilt_cm), x.hilt);
        chk("clamp_code", row, int'(clamp_code), x.code);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_m     = '0;
        cfg_cm    = '0;
        cfg_mask  = '0;
        ignite    = 1'b0;
        retract   = 1'b0;

        //            rst v  m   cm   mask  ig rt  rdy st l0  l1  tgt hilt code
        tbl.push_back(mk(1, 0, 0,  0,  2'b00, 0, 0, 0, 0, 0,  0,  50, 0,  0));
        tbl.push_back(mk(0, 1, -1, 0,  2'b01, 0, 0, 1, 0, 0,  0,  50, 0,  1));
        tbl.push_back(mk(0, 1, 0,  100, 2'b01, 0, 0, 1, 0, 0,  0, 100, 0,  4));
        tbl.push_back(mk(0, 1, 1,  1,  2'b01, 0, 0, 1, 0, 0,  0, 100, 0,  3));
        tbl.push_back(mk(0, 1, 0,  0,  2'b01, 0, 0, 1, 0, 0,  0,  50, 0,  2));
        tbl.push_back(mk(0, 1, 0,  23, 2'b11, 1, 0, 1, 1, 0,  0,  23, 0,  0));
        tbl.push_back(mk(0, 0, 0,  0,  2'b00, 0, 0, 0, 1, 5,  5,  23, 10, 0));
        tbl.push_back(mk(0, 0, 0,  0,  2'b00, 0, 0, 0, 1, 10, 10, 23, 10, 0));
        tbl.push_back(mk(0, 0, 0,  0,  2'b00, 0, 0, 0, 1, 15, 15, 23, 10, 0));
        tbl.push_back(mk(0, 0, 0,  0,  2'b00, 0, 0, 0, 1, 20, 20, 23, 10, 0));
        tbl.push_back(mk(0, 0, 0,  0,  2'b00, 0, 0, 0, 2, 23, 23, 23, 10, 0));
        tbl.push_back(mk(0, 1, 0,  23, 2'b11, 0, 0, 1, 2, 23, 23, 23, 10, 0));
        tbl.push_back(mk(0, 1, 0,  80, 2'b11, 0, 0, 1, 1, 23, 23, 80, 10, 0));
        tbl.push_back(mk(0, 0, 0,  0,  2'b00, 0, 0, 0, 1, 28, 28, 80, 10, 0));
        tbl.push_back(mk(0, 0, 0,  0,  2'b00, 0, 0, 0, 1, 33, 33, 80, 10, 0));
        tbl.push_back(mk(0, 1, 0,  10, 2'b01, 1, 1, 0, 3, 33, 33, 80, 10, 0));
        tbl.push_back(mk(0, 0, 0,  0,  2'b00, 1, 0, 0, 3, 28, 28, 80, 10, 0));
        tbl.push_back(mk(0, 0, 0,  0,  2'b00, 0, 0, 0, 3, 23, 23, 80, 10, 0));
        tbl.push_back(mk(0, 0, 0,  0,  2'b00, 0, 0, 0, 3, 18, 18, 80, 10, 0));
        tbl.push_back(mk(0, 0, 0,  0,  2'b00, 0, 0, 0, 3, 13, 13, 80, 10, 0));
        tbl.push_back(mk(0, 0, 0,  0,  2'b00, 0, 0, 0, 3, 8,  8,  80, 10, 0));
        tbl.push_back(mk(0, 0, 0,  0,  2'b00, 0, 0, 0, 3, 3,  3,  80, 10, 0));
        tbl.push_back(mk(0, 0, 0,  0,  2'b00, 0, 0, 0, 0, 0,  0,  80, 10, 0));

        foreach (tbl[i]) apply(tbl[i], i);

        // Single blade up to 100, down to 50, then retract while a request is pending.
        apply(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 50, 0, 0), 100);
        apply(mk(0, 1, 1, 0, 2'b01, 1, 0, 1, 1, 0, 0, 100, 0, 0), 101);
        for (int k = 1; k <= 20; k++) begin
            apply(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, (k == 20) ? 2 : 1, 5 * k, 0, 100, 0, 0),
                  101 + k);
        end
        apply(mk(0, 1, 0, 50, 2'b01, 0, 0, 1, 1, 100, 0, 50, 0, 0), 130);
        for (int k = 1; k <= 10; k++) begin
            apply(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, (k == 10) ? 2 : 1, 100 - 5 * k, 0, 50, 0, 0),
                  130 + k);
        end
        apply(mk(0, 1, 0, 70, 2'b01, 0, 1, 0, 3, 50, 0, 50, 0, 0), 150);
        for (int k = 1; k <= 10; k++) begin
            apply(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, (k == 10) ? 0 : 3, 50 - 5 * k, 0, 50, 0, 0),
                  150 + k);
        end

        // Reset in the middle of a retract, then mask-zero requests and ignored ignites.
        apply(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 50, 0, 0), 200);
        apply(mk(0, 1, 0, 80, 2'b11, 1, 0, 1, 1, 0, 0, 80, 0, 0), 201);
        for (int k = 1; k <= 8; k++) begin
            apply(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 5 * k, 5 * k, 80, 10, 0), 201 + k);
        end
        apply(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 3, 40, 40, 80, 10, 0), 210);
        apply(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 3, 35, 35, 80, 10, 0), 211);
        apply(mk(1, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 50, 0, 0), 212);
        apply(mk(0, 1, 0, 70, 2'b00, 0, 0, 1, 0, 0, 0, 50, 0, 5), 213);
        apply(mk(0, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 50, 0, 5), 214);
        apply(mk(0, 1, 0, 70, 2'b00, 1, 0, 1, 0, 0, 0, 50, 0, 5), 215);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
